// File: rtl/fetch_decode_pipe.sv
// fetch_decode_pipe
//   Fetch/decode front end of the single-issue MIPS-style core. Holds the
//   fetch PC, the instruction ROM (isa), the IF/ID pipeline register and the
//   32-entry register bank. It supports stall, flush and branch redirect, and
//   forwards a same-cycle WB write straight onto the read ports.
//
// Parameters
//   DATA_W     register/operand width (instruction width is fixed at 32)
//   ADDR_W     byte-address PC width; PC wraps modulo 2^ADDR_W
//   IMEM_DEPTH number of instruction words in isa
//   PC_STEP    PC increment per fetch
//   IMEM_INIT  ROM image, word i at bits [i*32 +: 32]
//
// Ports
//   clk, rst               rising-edge clock, synchronous active-high reset
//   stall, flush           hold PC + IF/ID / squash IF/ID into a bubble
//   branch_taken/_target   redirect PC and squash IF/ID
//   regWrite/writeReg/
//   writeData              register-bank write port from WB
//   pc                     current fetch PC
//   pc_plus4               PC of the IF/ID instruction plus PC_STEP
//   valid                  IF/ID holds a real instruction
//   opcode/rs/rt/rd/funct  decoded instruction fields
//   imm_ext                sign-extended 16-bit immediate
//   readData1/readData2    bank[rs] / bank[rt] with write-through forwarding
module fetch_decode_pipe #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 7,
    parameter int IMEM_DEPTH = 32,
    parameter int PC_STEP    = 4,
    parameter logic [IMEM_DEPTH*32-1:0] IMEM_INIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              regWrite,
    input  logic [4:0]        writeReg,
    input  logic [DATA_W-1:0] writeData,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              valid,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [5:0]        funct,
    output logic [DATA_W-1:0] imm_ext,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    typedef struct packed {
        logic [31:0]       instr;
        logic [ADDR_W-1:0] pc;
        logic              valid;
    } ifid_t;

    localparam ifid_t BUBBLE = '{instr: 32'h0, pc: '0, valid: 1'b0};

    logic [31:0]       isa [IMEM_DEPTH];
    logic [DATA_W-1:0] bank [32];

    logic [ADDR_W-1:0] pc_q, pc_d;
    ifid_t             ifid_q, ifid_d;
    logic [31:0]       fetch_word;
    logic [ADDR_W-3:0] fetch_idx;

    // Instruction ROM image
    for (genvar g = 0; g < IMEM_DEPTH; g++) begin : g_isa
        assign isa[g] = IMEM_INIT[g*32 +: 32];
    end

    // Word index is the byte PC shifted down by two; anything past the end of
    // the ROM fetches a NOP (all zeros) but is still a valid instruction.
    assign fetch_idx = pc_q[ADDR_W-1:2];

    always_comb begin
        fetch_word = 32'h0;
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            if (32'(fetch_idx) == i) fetch_word = isa[i];
        end
    end

    // Priority: branch > flush > stall > advance (reset handled in the flop)
    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        if (branch_taken) begin
            pc_d   = branch_target;
            ifid_d = BUBBLE;
        end else if (flush) begin
            ifid_d = BUBBLE;
            if (!stall) pc_d = pc_q + STEP;
        end else if (!stall) begin
            pc_d   = pc_q + STEP;
            ifid_d = '{instr: fetch_word, pc: pc_q, valid: 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= '0;
            ifid_q <= BUBBLE;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    // Bank has no reset so preloaded contents survive rst; writes ignore
    // stall/flush/rst entirely. r0 is never written.
    always_ff @(posedge clk) begin
        if (regWrite && writeReg != 5'd0) bank[writeReg] <= writeData;
    end

    // Decode is purely combinational off IF/ID
    assign pc       = pc_q;
    assign pc_plus4 = ifid_q.pc + STEP;
    assign valid    = ifid_q.valid;
    assign opcode   = ifid_q.instr[31:26];
    assign rs       = ifid_q.instr[25:21];
    assign rt       = ifid_q.instr[20:16];
    assign rd       = ifid_q.instr[15:11];
    assign funct    = ifid_q.instr[5:0];
    assign imm_ext  = {{(DATA_W-16){ifid_q.instr[15]}}, ifid_q.instr[15:0]};

    // r0 reads zero explicitly (its bank entry is never written); otherwise a
    // write in flight to the same register is forwarded in the same cycle.
    always_comb begin
        if (rs == 5'd0)                         readData1 = '0;
        else if (regWrite && writeReg == rs)    readData1 = writeData;
        else                                    readData1 = bank[rs];
        if (rt == 5'd0)                         readData2 = '0;
        else if (regWrite && writeReg == rt)    readData2 = writeData;
        else                                    readData2 = bank[rt];
    end

endmodule

// File: tb/tb_fetch_decode_pipe.sv
module tb_fetch_decode_pipe;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 7;
    localparam int DEPTH  = 16;

    // I0 add  r3,r1,r2 ; I1 lw r6,-4(r5) ; I2 addi r7,r0,16 ; I3 sub r12,r10,r11
    // isa[4] filler, isa[5] lui r15,0x1234, isa[15] pattern word, rest zero
    localparam logic [DEPTH*32-1:0] INIT = {
        32'hAAAA5555, {9{32'h0}}, 32'h3C0F1234, 32'h11111111,
        32'h014B6022, 32'h20070010, 32'h8CA6FFFC, 32'h00221820};

    logic              clk = 1'b0;
    logic              rst, stall, flush, branch_taken, regWrite;
    logic [ADDR_W-1:0] branch_target;
    logic [4:0]        writeReg;
    logic [DATA_W-1:0] writeData;
    logic [ADDR_W-1:0] pc, pc_plus4;
    logic              valid;
    logic [5:0]        opcode, funct;
    logic [4:0]        rs, rt, rd;
    logic [DATA_W-1:0] imm_ext, readData1, readData2;

    int errors = 0;
    int checks = 0;

    fetch_decode_pipe #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMEM_DEPTH(DEPTH),
        .PC_STEP(4), .IMEM_INIT(INIT)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .pc(pc), .pc_plus4(pc_plus4), .valid(valid), .opcode(opcode),
        .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm_ext(imm_ext),
        .readData1(readData1), .readData2(readData2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0; branch_taken = 0; branch_target = '0;
        regWrite = 0; writeReg = '0; writeData = '0;
        step(); step();
        rst = 0;
        // reset state
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_opcode", 32'(opcode), 32'h0);
        check("rst_rs", 32'(rs), 32'h0);
        check("rst_imm", imm_ext, 32'h0);
        check("rst_rd1", readData1, 32'h0);

        // 1: free run
        step();
        check("t1_pc4", 32'(pc), 32'h4);
        check("t1_valid", 32'(valid), 32'h1);
        check("t1_rs", 32'(rs), 32'd1);
        check("t1_rt", 32'(rt), 32'd2);
        check("t1_rd", 32'(rd), 32'd3);
        check("t1_funct", 32'(funct), 32'h20);
        check("t1_pcp4", 32'(pc_plus4), 32'h4);
        step();
        check("t1_pc8", 32'(pc), 32'h8);
        check("t1_i1_op", 32'(opcode), 32'h23);
        check("t1_i1_rs", 32'(rs), 32'd5);
        check("t1_i1_rt", 32'(rt), 32'd6);
        check("t1_i1_imm", imm_ext, 32'hFFFFFFFC);

        // 2: stall three cycles with I1 held; 4: forwarding while held
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_pc", 32'(pc), 32'h8);
            check("t2_rs", 32'(rs), 32'd5);
            check("t2_imm", imm_ext, 32'hFFFFFFFC);
            check("t2_valid", 32'(valid), 32'h1);
        end
        regWrite = 1; writeReg = 5'd5; writeData = 32'hDEADBEEF;
        #1 check("t4_fwd_rd1", readData1, 32'hDEADBEEF);
        step();
        regWrite = 1; writeReg = 5'd6; writeData = 32'h0BADF00D;
        #1 check("t4_bank_rd1", readData1, 32'hDEADBEEF);
        check("t4_fwd_rd2", readData2, 32'h0BADF00D);
        check("t4_bank5", dut.bank[5], 32'hDEADBEEF);
        step();
        regWrite = 0;
        #1 check("t4_bank_rd2", readData2, 32'h0BADF00D);
        stall = 0;
        step();
        check("t2_resume_pc", 32'(pc), 32'hC);
        check("t2_resume_rt", 32'(rt), 32'd7);
        check("t2_resume_imm", imm_ext, 32'h10);
        regWrite = 1; writeReg = 5'd0; writeData = 32'h12345678;
        #1 check("t4_r0_rd1", readData1, 32'h0);
        step();
        regWrite = 0;
        check("t1_i3_rs", 32'(rs), 32'd10);
        check("t1_i3_rd", 32'(rd), 32'd12);
        check("t1_i3_funct", 32'(funct), 32'h22);
        check("t1_pc16", 32'(pc), 32'h10);

        // 3: branch overrides stall
        stall = 1; branch_taken = 1; branch_target = 7'h14;
        step();
        stall = 0; branch_taken = 0;
        check("t3_pc", 32'(pc), 32'h14);
        check("t3_valid", 32'(valid), 32'h0);
        check("t3_opcode", 32'(opcode), 32'h0);
        step();
        check("t3_isa5_op", 32'(opcode), 32'h0F);
        check("t3_isa5_rt", 32'(rt), 32'd15);
        check("t3_isa5_imm", imm_ext, 32'h1234);
        check("t3_isa5_valid", 32'(valid), 32'h1);
        check("t3_pcp4", 32'(pc_plus4), 32'h18);

        // flush alone: bubble, pc advances; flush+stall: bubble, pc holds
        flush = 1;
        step();
        check("fl_valid", 32'(valid), 32'h0);
        check("fl_pc", 32'(pc), 32'h1C);
        stall = 1;
        step();
        check("flst_pc", 32'(pc), 32'h1C);
        check("flst_valid", 32'(valid), 32'h0);
        flush = 0; stall = 0;

        // 5: end of ROM, past ROM, and PC wrap
        branch_taken = 1; branch_target = 7'h3C;
        step();
        branch_taken = 0;
        check("t5_pc60", 32'(pc), 32'h3C);
        step();
        check("t5_isa15_op", 32'(opcode), 32'h2A);
        check("t5_isa15_funct", 32'(funct), 32'h15);
        check("t5_isa15_imm", imm_ext, 32'h5555);
        step();
        check("t5_oob_valid", 32'(valid), 32'h1);
        check("t5_oob_op", 32'(opcode), 32'h0);
        check("t5_oob_imm", imm_ext, 32'h0);
        branch_taken = 1; branch_target = 7'h7C;
        step();
        branch_taken = 0;
        check("t5_pc7c", 32'(pc), 32'h7C);
        step();
        check("t5_wrap_pc", 32'(pc), 32'h0);
        check("t5_wrap_pcp4", 32'(pc_plus4), 32'h0);
        check("t5_wrap_valid", 32'(valid), 32'h1);
        step();
        check("t5_wrap_i0_rs", 32'(rs), 32'd1);

        // 6: reset mid-run, bank survives; reset beats branch
        regWrite = 1; writeReg = 5'd3; writeData = 32'd7;
        step();
        regWrite = 0;
        rst = 1; branch_taken = 1; branch_target = 7'h40;
        step();
        rst = 0; branch_taken = 0;
        check("t6_pc", 32'(pc), 32'h0);
        check("t6_valid", 32'(valid), 32'h0);
        check("t6_opcode", 32'(opcode), 32'h0);
        check("t6_bank3", dut.bank[3], 32'd7);
        check("t6_bank5", dut.bank[5], 32'hDEADBEEF);
        step();
        check("t6_i0_rs", 32'(rs), 32'd1);
        check("t6_pc4", 32'(pc), 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
